// File: rtl/fifo_deq_packer.sv
// rtl/fifo_deq_packer.sv - packs N_PACK consecutive FIFO entries into one wide valid/ready word
module fifo_deq_packer #(
  parameter  int ENTRY_WIDTH = 4,
  parameter  int N_PACK      = 4,
  localparam int CTR_WIDTH   = $clog2(N_PACK) + 1,
  localparam int WORD_WIDTH  = N_PACK * ENTRY_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  // FIFO dequeue side
  input  logic                   deq_valid,
  input  logic [ENTRY_WIDTH-1:0] deq_data,
  output logic                   deq_ready,
  // packed word side
  output logic                   out_valid,
  output logic [WORD_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  // state load / observation
  input  logic                   init,
  input  logic [WORD_WIDTH-1:0]  init_pack_reg_state,
  input  logic [CTR_WIDTH-1:0]   init_count_state,
  output logic [WORD_WIDTH-1:0]  current_pack_reg_state,
  output logic [CTR_WIDTH-1:0]   current_count_state
);

  localparam logic [CTR_WIDTH-1:0] FULL_COUNT = CTR_WIDTH'(N_PACK);
  localparam logic [CTR_WIDTH-1:0] ONE_COUNT  = CTR_WIDTH'(1);

  logic [WORD_WIDTH-1:0] pack_reg_q;
  logic [CTR_WIDTH-1:0]  count_q;

  logic [WORD_WIDTH-1:0] pack_cur;
  logic [CTR_WIDTH-1:0]  count_cur;
  logic [WORD_WIDTH-1:0] pack_next;
  logic [CTR_WIDTH-1:0]  count_next;

  logic in_fire;
  logic out_fire;

  // While init is held, the loaded values are the live state, so outputs follow init_* in the same timestep.
  always_comb begin
    pack_cur  = pack_reg_q;
    count_cur = count_q;
    if (init) begin
      pack_cur  = init_pack_reg_state;
      count_cur = init_count_state;
    end
  end

  // Handshake outputs; out_ready reaches deq_ready combinationally so a full word can drain and refill in one cycle.
  always_comb begin
    out_valid = (count_cur == FULL_COUNT);
    out_data  = pack_cur;
    deq_ready = (count_cur < FULL_COUNT) | out_ready;
    in_fire   = deq_valid & deq_ready;
    out_fire  = out_valid & out_ready;
    current_pack_reg_state = pack_cur;
    current_count_state    = count_cur;
  end

  // Next-state: write the popped entry into slot[count]; a drained word restarts at slot 0 without clearing stale slots.
  always_comb begin
    pack_next  = pack_cur;
    count_next = count_cur;
    if (out_fire) begin
      if (in_fire) begin
        pack_next[ENTRY_WIDTH-1:0] = deq_data;
        count_next                 = ONE_COUNT;
      end else begin
        count_next = '0;
      end
    end else if (in_fire) begin
      for (int i = 0; i < N_PACK; i++) begin
        if (count_cur == CTR_WIDTH'(i)) begin
          pack_next[i*ENTRY_WIDTH +: ENTRY_WIDTH] = deq_data;
        end
      end
      count_next = count_cur + ONE_COUNT;
    end
  end

  // State registers: init loads asynchronously and overrides the synchronous reset and normal update.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      pack_reg_q <= init_pack_reg_state;
      count_q    <= init_count_state;
    end else if (rst) begin
      pack_reg_q <= '0;
      count_q    <= '0;
    end else begin
      pack_reg_q <= pack_next;
      count_q    <= count_next;
    end
  end

endmodule
